// File: rtl/ws2812_frame_sched.sv
// WS2812 frame scheduler: double-buffered pixel banks feeding a
// per-pixel serializer, followed by a low latch gap.
module ws2812_frame_sched #(
  parameter  int NUM_LEDS     = 5,
  parameter  int LATCH_CYCLES = 5000,
  localparam int AW           = $clog2(NUM_LEDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          frame_start,
  input  logic          tx_ready,
  input  logic          tx_done,
  output logic          tx_valid,
  output logic [23:0]   tx_data,
  output logic          busy,
  output logic          frame_done
);

  localparam int CW = $clog2(LATCH_CYCLES + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_LEDS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_LATCH
  } state_t;

  state_t        r_state;
  logic          r_sel;
  logic          r_pend;
  logic [AW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic          r_tx_valid;
  logic [23:0]   r_tx_data;
  logic          r_done;
  logic [23:0]   r_bank [2][NUM_LEDS];

  logic w_wr_ok;
  logic w_start;

  assign w_wr_ok = rst_n && wr_en && (32'(wr_addr) < NUM_LEDS);
  assign w_start = frame_start | r_pend;

  // Banks are storage only; they survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok)
      r_bank[r_sel][wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sel      <= 1'b0;
      r_pend     <= 1'b0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (frame_start && r_state != S_IDLE)
        r_pend <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_sel   <= ~r_sel;
            r_idx   <= '0;
            r_pend  <= 1'b0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_tx_data  <= r_bank[~r_sel][r_idx];
          r_tx_valid <= 1'b1;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tx_done) begin
            if (r_idx == LAST_IDX) begin
              r_cnt   <= '0;
              r_state <= S_LATCH;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_LOAD;
            end
          end
        end
        S_LATCH: begin
          if (r_cnt == LAST_CNT) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_valid   = r_tx_valid;
  assign tx_data    = r_tx_data;
  assign frame_done = r_done;
  // A queued frame keeps busy up through the frame_done cycle.
  assign busy       = (r_state != S_IDLE) | r_pend;

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Scoreboard bench for ws2812_frame_sched: bank model feeds an
// expected-pixel queue, a negedge monitor pops and compares.
module tb_ws2812_frame_sched;

  localparam int N  = 5;
  localparam int LC = 5000;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          frame_start;
  logic          tx_ready;
  logic          tx_done;
  logic          tx_valid;
  logic [23:0]   tx_data;
  logic          busy;
  logic          frame_done;

  always #5 clk = ~clk;

  ws2812_frame_sched #(
    .NUM_LEDS     (N),
    .LATCH_CYCLES (LC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_start (frame_start),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  typedef struct {
    logic [23:0] d;
    bit          last;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [23:0] mbank [2][N];
  bit          msel = 1'b0;
  int          xfer_cnt = 0;
  int          frames_seen = 0;
  bit          rdy_low = 1'b0;
  bit          rdy_rand = 1'b0;
  bit          spur = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepting a frame shows the current write bank and flips it.
  function automatic void push_frame();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.d    = mbank[msel][i];
      e.last = (i == N - 1);
      exp_q.push_back(e);
    end
    msel = ~msel;
  endfunction

  task automatic wr(logic [AW-1:0] a, logic [23:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    if (32'(a) < N && rst_n)
      mbank[msel][a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    push_frame();
    tick();
    frame_start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_lat1", 32'(tx_valid), 0);
    tick();
    chk("start_lat2", 32'(tx_valid), 1);
  endtask

  task automatic wait_fd(string nm);
    int n = 0;
    while (frame_done !== 1'b1 && n < 20000) begin
      tick();
      n++;
    end
    if (frame_done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting frame_done got 0 expected 1", nm);
    end
  endtask

  task automatic wait_xfer(int target);
    int n = 0;
    while (xfer_cnt < target && n < 2000) begin
      tick();
      n++;
    end
    if (xfer_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL wait_xfer: got %0d expected %0d", xfer_cnt, target);
    end
  endtask

  // Serializer stand-in: tx_done pulse 24 cycles after each transfer.
  initial begin
    int cnt = 0;
    bit hs;
    tx_ready = 1'b1;
    tx_done  = 1'b0;
    forever begin
      @(negedge clk);
      hs = tx_valid && tx_ready && rst_n;
      @(posedge clk);
      #1;
      tx_done = spur || (cnt == 1);
      spur = 1'b0;
      if (cnt > 0) cnt--;
      if (hs) cnt = 24;
      if (rdy_low)       tx_ready = 1'b0;
      else if (rdy_rand) tx_ready = 1'($urandom_range(0, 1));
      else               tx_ready = 1'b1;
    end
  end

  // Monitor
  initial begin
    bit          prev_hs = 0;
    bit          prev_stall = 0;
    bit          prev_fd = 0;
    bit          wait_last = 0;
    logic [23:0] prev_d = '0;
    int          cyc = 0;
    int          last_done = 0;
    int          fin = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        prev_hs    = 0;
        prev_stall = 0;
        prev_fd    = 0;
        wait_last  = 0;
        fin        = 0;
      end else begin
        if (prev_hs)
          chk("valid_drop", 32'(tx_valid), 0);
        if (prev_stall) begin
          chk("hold_valid", 32'(tx_valid), 1);
          chk("hold_data", 32'(tx_data), 32'(prev_d));
        end
        if (tx_done && wait_last) begin
          last_done = cyc;
          wait_last = 0;
        end
        if (tx_valid && tx_ready) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer: got %06h expected none", tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("pixel", 32'(tx_data), 32'(e.d));
            if (e.last) begin
              wait_last = 1;
              fin++;
            end
          end
        end
        if (frame_done) begin
          frames_seen++;
          chk("fd_after_frame", 32'(fin > 0), 1);
          chk("fd_pulse", 32'(prev_fd), 0);
          chk("latch_len", 32'(cyc - last_done), 32'(LC + 1));
          if (fin > 0) fin--;
        end
        prev_hs    = tx_valid && tx_ready;
        prev_stall = tx_valid && !tx_ready;
        prev_d     = tx_data;
        prev_fd    = frame_done;
      end
    end
  end

  // Driver
  initial begin
    logic [23:0] v [N];
    int  base;
    bit  act;
    v[0] = 24'hFF00FF;
    v[1] = 24'h00FF00;
    v[2] = 24'hAAAA55;
    v[3] = 24'h123456;
    v[4] = 24'hA543D5;
    rst_n       = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    frame_start = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fd", 32'(frame_done), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < N; i++) wr(AW'(i), v[i]);
    wr(AW'(7), 24'h777777);

    // Writes under reset must not land.
    rst_n   = 1'b0;
    wr_en   = 1'b1;
    wr_addr = '0;
    wr_data = 24'hDEADBE;
    tick();
    tick();
    wr_en = 1'b0;
    rst_n = 1'b1;
    tick();

    // Frame A with a stalled first pixel
    rdy_low = 1'b1;
    tick();
    tick();
    start_frame();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) spur = 1'b1;
      tick();
      chk("stall_valid", 32'(tx_valid), 1);
      chk("stall_data", 32'(tx_data), 32'h00FF00FF);
    end
    rdy_low = 1'b0;
    for (int i = 0; i < N; i++)
      wr(AW'(i), (i == 2) ? 24'h010203 : 24'($urandom()));
    wr(AW'(7), 24'($urandom()));
    wait_fd("fd_A");
    tick();
    chk("fd_A_one", 32'(frame_done), 0);
    chk("idle_A_busy", 32'(busy), 0);

    // Frame B, with three merged requests queuing frame C
    rdy_rand = 1'b1;
    base = xfer_cnt;
    start_frame();
    wait_xfer(base + 1);
    for (int k = 0; k < 3; k++) begin
      frame_start = 1'b1;
      if (k == 0) push_frame();
      tick();
      frame_start = 1'b0;
      repeat (3) tick();
    end
    wait_fd("fd_B");
    chk("b2b_busy0", 32'(busy), 1);
    tick();
    chk("b2b_busy1", 32'(busy), 1);
    chk("b2b_lat1", 32'(tx_valid), 0);
    tick();
    chk("b2b_lat2", 32'(tx_valid), 1);
    wait_fd("fd_C");
    chk("c_busy", 32'(busy), 0);
    tick();
    chk("c_fd_one", 32'(frame_done), 0);
    chk("c_no_extra", 32'(busy), 0);
    rdy_rand = 1'b0;

    // Frame D, aborted by reset while waiting on pixel 3
    for (int i = 0; i < 8; i++)
      wr(AW'($urandom_range(0, 7)), 24'($urandom()));
    base = xfer_cnt;
    start_frame();
    wait_xfer(base + 4);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    msel  = 1'b0;
    chk("abort_valid", 32'(tx_valid), 0);
    chk("abort_data", 32'(tx_data), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_fd", 32'(frame_done), 0);
    act = 1'b0;
    repeat (40) begin
      tick();
      act |= tx_valid | busy | frame_done;
    end
    chk("abort_quiet", 32'(act), 0);

    // Frame E from bank 0 after reset
    start_frame();
    wait_fd("fd_E");
    tick();
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("frames", 32'(frames_seen), 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
